// File: rtl/acc_pkg.sv
`default_nettype none
// =============================================================================
// Package  : acc_pkg
// Brief    : Shared types and constants for the accumulator readout engine.
// Revision : 1.0 - initial release
// =============================================================================
package acc_pkg;

  // Cycles from an accumulator read enable to valid read data.
  localparam int ACC_RD_LAT = 2;

  // Native accumulator word width.
  localparam int ACC_DATA_WIDTH = 64;

  // Readout engine control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  // Output FIFO entry layout: last-beat tag above the data word. The engine
  // packs entries of its own DATA_WIDTH in this same {last, data} order.
  typedef struct packed {
    logic                      last;
    logic [ACC_DATA_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// =============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with occupancy count; head word shown on rdata_o
//            and held until it is popped.
// Revision : 1.0 - initial release
// =============================================================================
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             w_do_pop;

  // A pop on an empty FIFO is ignored; the writer never pushes when full.
  assign w_do_pop = pop_i & (count_q != '0);

  // Storage array, cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/acc_drain.sv
`default_nettype none
// =============================================================================
// Module   : acc_drain
// Brief    : Accumulator readout engine. Sweeps an address range through the
//            accumulator read port (2-cycle latency) and streams each word out
//            on a valid/ready interface at up to one word per cycle.
// Options  : ACC_DRAIN_CLEAR_EN - zero each entry with a write issued in the
//            same cycle as its read.
// Revision : 1.0 - initial release
// =============================================================================
module acc_drain
  import acc_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_en,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  output logic                  acc_mode,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W  = FCNT_W + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  drain_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [ACC_RD_LAT-1:0]   lat_vld_q;
  logic [ACC_RD_LAT-1:0]   lat_last_q;

  logic                    w_issue;
  logic                    w_issue_last;
  logic                    w_credit_ok;
  logic                    w_pop;
  logic [CNT_W-1:0]        w_inflight;
  logic [FCNT_W-1:0]       w_fifo_count;
  logic                    w_fifo_empty;
  logic [DATA_WIDTH:0]     w_fifo_head;

  // Reads already in the RAM pipeline, not yet landed in the FIFO.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ACC_RD_LAT; i++) begin
      w_inflight = w_inflight + {{(CNT_W-1){1'b0}}, lat_vld_q[i]};
    end
  end

  // A read may issue only if its word is guaranteed a FIFO slot on arrival.
  assign w_credit_ok = (({1'b0, w_fifo_count} + w_inflight) < DEPTH_C);
  assign w_pop       = m_valid & m_ready;

  // Next-state, address and word-count logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = length;
          state_d     = (length == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (w_credit_ok) begin
          w_issue     = 1'b1;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_ONE) begin
            w_issue_last = 1'b1;
            state_d      = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_pop && m_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address and remaining-count registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  // Latency shift register: valid and last tag follow each read to the RAM output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_vld_q  <= '0;
      lat_last_q <= '0;
    end else begin
      lat_vld_q  <= {lat_vld_q[ACC_RD_LAT-2:0], w_issue};
      lat_last_q <= {lat_last_q[ACC_RD_LAT-2:0], w_issue_last};
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (lat_vld_q[ACC_RD_LAT-1]),
    .wdata_i ({lat_last_q[ACC_RD_LAT-1], rd_rdata}),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_head),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign rd_en    = w_issue;
  assign rd_addr  = addr_q;
  assign m_valid  = ~w_fifo_empty;
  assign m_data   = w_fifo_head[DATA_WIDTH-1:0];
  assign m_last   = w_fifo_head[DATA_WIDTH];
  assign acc_mode = 1'b0;
  assign wr_addr  = addr_q;
  assign wr_wdata = '0;

`ifdef ACC_DRAIN_CLEAR_EN
  // The clear write lands after the read has sampled the old value.
  assign wr_en = w_issue;
`else
  assign wr_en = 1'b0;
`endif
  assign wr_we = wr_en;

endmodule
`default_nettype wire

// File: tb/tb_acc_drain.sv
`default_nettype none
// =============================================================================
// Module   : tb_acc_drain
// Brief    : Self-checking bench for acc_drain with an accumulator RAM model
//            and a beat/address scoreboard. Honours ACC_DRAIN_CLEAR_EN.
// Revision : 1.0 - initial release
// =============================================================================
module tb_acc_drain;

  localparam int AW    = 9;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, rd_en, wr_en, wr_we, acc_mode;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_rdata = '0;
  logic [DW-1:0] wr_wdata;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;

  acc_drain #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_rdata  (rd_rdata),
    .wr_en     (wr_en),
    .wr_we     (wr_we),
    .wr_addr   (wr_addr),
    .wr_wdata  (wr_wdata),
    .acc_mode  (acc_mode),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator RAM model: 2-cycle read, writes land 3 cycles after issue.
  logic [DW-1:0] mem [1 << AW];
  bit            init_done = 1'b0;
  bit            rp_v = 1'b0;
  logic [AW-1:0] rp_a = '0;
  bit            wp1_v = 1'b0, wp2_v = 1'b0;
  logic [AW-1:0] wp1_a = '0, wp2_a = '0;
  logic [DW-1:0] wp1_d = '0, wp2_d = '0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 64'(i) - 64'd15;
      init_done <= 1'b1;
    end else if (wp2_v) begin
      mem[wp2_a] <= wp2_d;
    end
    rp_v <= rd_en;
    rp_a <= rd_addr;
    if (rp_v) rd_rdata <= mem[rp_a];
    wp1_v <= wr_en & wr_we;
    wp1_a <= wr_addr;
    wp1_d <= wr_wdata;
    wp2_v <= wp1_v;
    wp2_a <= wp1_a;
    wp2_d <= wp1_d;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard state shared between the stimulus and the monitor.
  logic [AW-1:0] exp_addr [$];
  logic [DW:0]   exp_q [$];
  int first_rd, first_valid, done_cyc, last_hs, done_cnt, busy_cnt, outstanding;
  bit            hold_v = 1'b0;
  logic [DW:0]   hold_d;
  logic [AW-1:0] mon_addr;
  logic [DW:0]   mon_beat;

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    outstanding = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        outstanding = 0;
        hold_v      = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (hold_v) begin
          check("m_valid_held", m_valid, 1);
          check("m_data_held", {m_last, m_data}, hold_d);
        end
        hold_v = m_valid && !m_ready;
        hold_d = {m_last, m_data};
        if (rd_en) begin
          if (first_rd < 0) first_rd = cyc;
          outstanding++;
          check("outstanding_le_depth", outstanding <= DEPTH, 1);
          if (exp_addr.size() > 0) begin
            mon_addr = exp_addr.pop_front();
            check("rd_addr", rd_addr, mon_addr);
          end else begin
            mon_addr = rd_addr;
            check("rd_en_unexpected", rd_en, 0);
          end
          check("acc_mode", acc_mode, 0);
`ifdef ACC_DRAIN_CLEAR_EN
          check("clr_wr_en", {wr_en, wr_we}, 2'b11);
          check("clr_wr_addr", wr_addr, mon_addr);
          check("clr_wr_wdata", wr_wdata, 0);
`else
          check("wr_disabled", {wr_en, wr_we}, 0);
`endif
        end else if (wr_en || wr_we) begin
          check("wr_spurious", {wr_en, wr_we}, 0);
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
          outstanding--;
          if (exp_q.size() > 0) begin
            mon_beat = exp_q.pop_front();
            check("m_data", m_data, mon_beat[DW-1:0]);
            check("m_last", m_last, mon_beat[DW]);
          end else begin
            check("beat_unexpected", m_valid, 0);
          end
          if (m_last) last_hs = cyc;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_en_we"}, {wr_en, wr_we}, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_wdata"}, wr_wdata, 0);
    check({tag, "_acc_mode"}, acc_mode, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_last"}, m_last, 0);
  endtask

  // Queue the expected reads and beats for one command.
  task automatic push_expect(input logic [AW-1:0] base, input int len, input bit exp_zero);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      a = AW'(int'(base) + i);
      d = exp_zero ? '0 : mem[a];
      exp_addr.push_back(a);
      exp_q.push_back({(i == len - 1), d});
    end
  endtask

  task automatic run_cmd(input logic [AW-1:0] base, input int len, input bit stall, input bit exp_zero);
    int t0;
    int budget;
    @(posedge clk); #1;
    first_rd = -1; first_valid = -1; done_cyc = -1; last_hs = -1;
    done_cnt = 0; busy_cnt = 0;
    push_expect(base, len, exp_zero);
    start = 1'b1; base_addr = base; length = (AW + 1)'(len);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    while (done_cyc < 0 && budget < 2000) begin
      m_ready = stall ? !((cyc - t0) >= 5 && (cyc - t0) <= 14) : 1'b1;
      @(posedge clk); #1;
      budget++;
    end
    m_ready = 1'b1;
    check("cmd_completed", done_cyc >= 0, 1);
    if (len != 0) begin
      check("first_rd_cycle", first_rd, t0 + 1);
      check("first_valid_cycle", first_valid, t0 + 4);
      check("done_after_last", done_cyc, last_hs + 1);
      if (!stall) check("last_beat_cycle", last_hs, t0 + 3 + len);
    end else begin
      check("len0_done_cycle", done_cyc, t0 + 1);
      check("len0_no_read", first_rd, -1);
    end
    check("busy_cycles", busy_cnt, done_cyc - t0);
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("idle_busy", busy, 0);
    check("addr_queue_empty", exp_addr.size(), 0);
    check("beat_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    run_cmd(9'h010, 4, 1'b0, 1'b0);
    run_cmd(9'h1FE, 4, 1'b0, 1'b0);
    run_cmd(9'h080, 8, 1'b1, 1'b0);
    run_cmd(9'h000, 0, 1'b0, 1'b0);
    run_cmd(9'h020, 3, 1'b0, 1'b0);
`ifdef ACC_DRAIN_CLEAR_EN
    run_cmd(9'h020, 3, 1'b0, 1'b1);
`else
    run_cmd(9'h020, 3, 1'b0, 1'b0);
`endif

    // Abort a command while reads are being issued.
    @(posedge clk); #1;
    push_expect(9'h040, 8, 1'b0);
    start = 1'b1; base_addr = 9'h040; length = 10'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_issue_rd_en", rd_en, 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_addr.delete();
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_outputs("mid_reset_held");
    rstn = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_reset_quiet", {busy, rd_en, m_valid}, 0);
    end

    run_cmd(9'h010, 4, 1'b0, 1'b0);
    run_cmd(9'h100, 512, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
